// File: rtl/nic_port_arbiter.sv
// Shares the single cardinal_nic register port between two requesters (poll status, then transfer).
// Latency: request sampled in IDLE at edge E, ack pulses in cycle E+3; minimum 4 cycles per transaction.
// Backpressure: req_valid is held until req_ack; a failed poll returns to IDLE and priority flips.
module nic_port_arbiter #(
    parameter int DATA_W    = 64,
    parameter int MAX_RETRY = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    input  logic [1:0]        req_wr,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    output logic [1:0]        req_ack,
    output logic [DATA_W-1:0] req_rdata,
    output logic [1:0]        stall,
    output logic              busy,
    output logic              nicEn,
    output logic              nicEnWr,
    output logic [1:0]        addr,
    output logic [DATA_W-1:0] d_in,
    input  logic [DATA_W-1:0] d_out
);

    typedef enum logic [1:0] {IDLE, POLL, XFER, DONE} state_t;

    localparam logic [7:0] RETRY_LIMIT = 8'(MAX_RETRY);

    // NIC register map
    localparam logic [1:0] A_IN_BUF   = 2'b00;
    localparam logic [1:0] A_IN_STAT  = 2'b01;
    localparam logic [1:0] A_OUT_BUF  = 2'b10;
    localparam logic [1:0] A_OUT_STAT = 2'b11;

    state_t            state;
    logic              rr_ptr;
    logic              gid;
    logic              op;
    logic [DATA_W-1:0] wdata;
    logic [1:0][7:0]   fail;
    logic              grant;
    logic              poll_ok;

    // Round-robin pick: the pointed-to requester if it is asking, else the other one.
    always_comb begin
        grant = rr_ptr;
        if (!req_valid[rr_ptr]) begin
            grant = ~rr_ptr;
        end
    end

    // Send needs an empty output buffer (bit0 = 0); receive needs a full input buffer (bit0 = 1).
    assign poll_ok = d_out[0] ^ op;

    // Transaction sequencer; every NIC-facing output is registered so it changes only at the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            gid       <= 1'b0;
            op        <= 1'b0;
            wdata     <= '0;
            fail      <= '0;
            stall     <= 2'b00;
            req_ack   <= 2'b00;
            req_rdata <= '0;
            busy      <= 1'b0;
            nicEn     <= 1'b0;
            nicEnWr   <= 1'b0;
            addr      <= A_IN_BUF;
            d_in      <= '0;
        end else begin
            req_ack <= 2'b00;
            // Stall flag lags the counter by one cycle; a later clear in DONE overrides it.
            for (int i = 0; i < 2; i++) begin
                if (fail[i] >= RETRY_LIMIT) begin
                    stall[i] <= 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        gid     <= grant;
                        op      <= req_wr[grant];
                        wdata   <= grant ? req_wdata1 : req_wdata0;
                        state   <= POLL;
                        busy    <= 1'b1;
                        nicEn   <= 1'b1;
                        nicEnWr <= 1'b0;
                        addr    <= req_wr[grant] ? A_OUT_STAT : A_IN_STAT;
                        d_in    <= '0;
                    end
                end
                POLL: begin
                    if (poll_ok) begin
                        state   <= XFER;
                        nicEn   <= 1'b1;
                        nicEnWr <= op;
                        addr    <= op ? A_OUT_BUF : A_IN_BUF;
                        d_in    <= op ? wdata : '0;
                    end else begin
                        if (fail[gid] != 8'hFF) begin
                            fail[gid] <= fail[gid] + 8'd1;
                        end
                        rr_ptr  <= ~gid;
                        state   <= IDLE;
                        busy    <= 1'b0;
                        nicEn   <= 1'b0;
                        nicEnWr <= 1'b0;
                        addr    <= A_IN_BUF;
                        d_in    <= '0;
                    end
                end
                XFER: begin
                    // The input buffer is only readable during this cycle, so capture it here.
                    if (!op) begin
                        req_rdata <= d_out;
                    end
                    state        <= DONE;
                    nicEn        <= 1'b0;
                    nicEnWr      <= 1'b0;
                    addr         <= A_IN_BUF;
                    d_in         <= '0;
                    req_ack[gid] <= 1'b1;
                    fail[gid]    <= 8'd0;
                    stall[gid]   <= 1'b0;
                end
                DONE: begin
                    rr_ptr <= ~gid;
                    state  <= IDLE;
                    busy   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/nic_port_arbiter.md
Name: nic_port_arbiter

Overview:
- Controller that shares the single CPU-side register port of cardinal_nic between two requesters. Example requesters: PE core = requester 0, traffic generator = requester 1.
- Sequences each request as a status poll followed by a buffer transfer:
  - Send: poll output status (addr 11); if empty, write the output buffer (addr 10).
  - Receive: poll input status (addr 01); if full, read the input buffer (addr 00).
- Round-robin arbitration with per-requester starvation flags.
- Sits between the PEs and the NIC; drives nicEn, nicEnWr, addr and d_in directly.

Parameters:
DATA_W, 64, NIC data width.
MAX_RETRY, 15, consecutive failed polls before a requester's stall flag sets. Range 1..255.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset (asserted at 0).
req_valid  input  2  per-requester request; held high until the matching req_ack.
req_wr  input  2  per-requester op: 1 = send, 0 = receive.
req_wdata0  input  DATA_W  requester 0 send packet.
req_wdata1  input  DATA_W  requester 1 send packet.
req_ack  output  2  one-cycle completion pulse, one-hot.
req_rdata  output  DATA_W  received packet; valid while req_ack is high for a receive.
stall  output  2  per-requester starvation flag.
busy  output  1  high in any state other than IDLE.
nicEn  output  1  NIC enable.
nicEnWr  output  1  NIC write enable.
addr  output  2  NIC register address.
d_in  output  DATA_W  NIC write data.
d_out  input  DATA_W  NIC read data; combinational from addr while nicEn=1 and nicEnWr=0.

Behaviour:

NIC contract:
- Status registers report full in bit 0.
- Reading addr 00 clears input status at that edge.
- Writing addr 10 sets output status.

Reset:
- state = IDLE, rr_ptr = 0.
- Outputs: req_ack = 0, req_rdata = 0, stall = 0, busy = 0, nicEn = 0, nicEnWr = 0, addr = 00, d_in = 0.
- Fail counters = 0.
- Reset asserted mid-transaction aborts it: no ack, no NIC access.

FSM states: IDLE, POLL, XFER, DONE.

IDLE:
- If req_valid has any bit set, grant:
  - rr_ptr when that requester is valid;
  - otherwise the other requester.
- Latch gid, op and wdata at the edge, then go to POLL.
- NIC outputs idle: nicEn = 0, nicEnWr = 0, addr = 00, d_in = 0.

POLL:
- Drive nicEn = 1, nicEnWr = 0, addr = (op ? 11 : 01).
- Sample d_out[0] at the edge.
- Poll succeeds when send with d_out[0] = 0, or receive with d_out[0] = 1. On success, go to XFER.
- On failure:
  - increment fail[gid], saturating at 255;
  - set rr_ptr = ~gid;
  - go to IDLE.
  - The other requester, if valid, wins the next grant.

XFER:
- Send: nicEn = 1, nicEnWr = 1, addr = 10, d_in = latched wdata.
- Receive: nicEn = 1, nicEnWr = 0, addr = 00; capture d_out into req_rdata.
- Next state: DONE.

DONE:
- req_ack[gid] = 1 for exactly one cycle.
- Clear fail[gid] and stall[gid].
- Set rr_ptr = ~gid, then go to IDLE.

Latency and ack rules:
- Best case: request sampled in IDLE at edge E; POLL in E+1; XFER in E+2; ack in E+3.
- Minimum 4 cycles per transaction.
- req_rdata holds its value until the next receive completes.
- req_ack is never asserted for a send on an unfilled NIC, or for a receive from an empty NIC.

Stall flags:
- stall[i] is registered: it goes high the cycle after fail[i] reaches MAX_RETRY.
- It clears in the DONE cycle of requester i.

Request-change rules:
- Changes to req_wr or wdata after the latch are ignored for the current transaction.
- Dropping req_valid after the latch does not abort; the ack still fires.

Simultaneous requests:
- With both valid in IDLE, rr_ptr decides.
- After every completion or failed poll, priority moves to the other requester. Both requesters are therefore served alternately.

Test Plan:
1. Send, buffer empty: req_valid = 01, req_wr = 01, req_wdata0 = 1234, d_out[0] = 0 in POLL -> addr 11 then 10, d_in = 1234 with nicEnWr = 1 in XFER, req_ack = 01 at reset-release + 3 cycles.
2. Receive, buffer full: req_valid = 10, req_wr = 00, d_out = {poll: 1, xfer: 1314} -> addr 01 then 00, req_ack = 10 and req_rdata = 1314 in the same cycle.
3. Contention: both valid, both send, rr_ptr = 0, status empty -> acks in order 01 then 10, 4 cycles apart; next simultaneous pair is served in order 01, 10 again.
4. Failed poll: requester 0 sends with output status held full (d_out[0] = 1) -> no write to addr 10; after 15 polls stall = 01. Releasing status to 0 -> write, ack, and stall back to 00.
5. Failed poll plus waiting requester: requester 0 poll fails and requester 1 (receive, input full) is valid -> next grant goes to requester 1; req_ack = 10 before requester 0 retries.
6. Reset mid-XFER: reset low during an XFER send -> all outputs 0 asynchronously with no ack. After release, requester 0 still valid -> transaction restarts from POLL.
